// File: rtl/uart_baud_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen_if
// Description : Control/status bundle between the UART core and its baud-tick
//               generator.
//               Controls (core -> generator):
//                 enable     - run tick generation; low holds the block idle
//                 div_int    - integer divisor request (DIV_W bits)
//                 div_frac   - fractional divisor request (FRAC_W bits)
//                 div_load   - one-cycle pulse, capture div_int/div_frac
//                 rx_resync  - one-cycle pulse, restart rx bit phase
//               Status (generator -> core):
//                 rx_tick    - oversample tick, 1 clk wide
//                 rx_sample  - mid-bit strobe, 1 clk wide
//                 rx_phase   - rx phase within the bit (PH_W bits)
//                 tx_tick    - bit-rate tick, 1 clk wide
//                 div_pending- loaded divisor not yet applied
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int PH_W   = 4
);
    logic              enable;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              rx_resync;
    logic              rx_tick;
    logic              rx_sample;
    logic [PH_W-1:0]   rx_phase;
    logic              tx_tick;
    logic              div_pending;

    // UART core side
    modport master (
        output enable, div_int, div_frac, div_load, rx_resync,
        input  rx_tick, rx_sample, rx_phase, tx_tick, div_pending
    );

    // Baud generator side
    modport slave (
        input  enable, div_int, div_frac, div_load, rx_resync,
        output rx_tick, rx_sample, rx_phase, tx_tick, div_pending
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Fractional baud-tick generator. A down-counter plus a
//               fractional accumulator produce an oversample tick whose
//               average period is act_int + act_frac/2^FRAC_W clk cycles.
//               Two phase counters derive the mid-bit rx strobe and the
//               bit-rate tx tick from that oversample tick. The divisor is
//               double-buffered so a runtime change only ever takes effect
//               on a period boundary.
//               OVERSAMPLE must be a power of two and at least 4.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               bus        - uart_baud_gen_if.slave (enable, divisor load,
//                            rx resync in; rx/tx ticks, phase, pending out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int RESET_DIV  = 325,
    parameter int RESET_FRAC = 0
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    uart_baud_gen_if.slave bus
);

    localparam int                PH_W        = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]   PH_MID      = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0]  RST_INT     = DIV_W'(RESET_DIV);
    localparam logic [FRAC_W-1:0] RST_FRAC    = FRAC_W'(RESET_FRAC);
    localparam logic [DIV_W-1:0]  RST_EFF     = (RST_INT == '0) ? DIV_W'(1) : RST_INT;
    localparam logic [DIV_W-1:0]  RST_CNT     = RST_EFF - DIV_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [PH_W-1:0]   rx_ph;
    logic [PH_W-1:0]   tx_ph;
    logic              pending;
    logic              rx_tick_q;
    logic              rx_sample_q;
    logic              tx_tick_q;

    // ------------------------------------------------------------------
    // Combinational divider datapath
    // ------------------------------------------------------------------
    logic              tick;
    logic              apply;
    logic [DIV_W-1:0]  new_int;
    logic [FRAC_W-1:0] new_frac;
    logic [DIV_W-1:0]  eff_int;
    logic [FRAC_W:0]   acc_full;
    logic              carry;
    logic [DIV_W-1:0]  reload;

    always_comb begin
        tick  = bus.enable && (cnt == '0);
        // The pending divisor is adopted on a period boundary while running,
        // or straight away while idle, so no runt period can ever occur.
        apply = pending && (!bus.enable || tick);

        // The reload at the applying tick already uses the new divisor.
        new_int  = apply ? pend_int  : act_int;
        new_frac = apply ? pend_frac : act_frac;
        eff_int  = (new_int == '0) ? DIV_W'(1) : new_int;

        acc_full = {1'b0, acc} + {1'b0, new_frac};
        carry    = acc_full[FRAC_W];
        // eff_int - 1 + carry never exceeds eff_int, so it fits in DIV_W.
        reload   = eff_int - DIV_W'(1) + DIV_W'(carry);
    end

    // ------------------------------------------------------------------
    // Divisor double buffer. A load that coincides with the copy wins:
    // pend_* takes the new request and the pending flag stays set, while
    // act_* still receives the previously pending value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_int  <= RST_INT;
            pend_frac <= RST_FRAC;
            act_int   <= RST_INT;
            act_frac  <= RST_FRAC;
            pending   <= 1'b0;
        end else begin
            if (bus.div_load) begin
                pend_int  <= bus.div_int;
                pend_frac <= bus.div_frac;
                pending   <= 1'b1;
            end else if (apply) begin
                pending   <= 1'b0;
            end

            if (apply) begin
                act_int  <= pend_int;
                act_frac <= pend_frac;
            end
        end
    end

    // ------------------------------------------------------------------
    // Period counter and fractional accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= RST_CNT;
            acc <= '0;
        end else if (!bus.enable) begin
            // Preset so the first tick lands eff_int edges after enable.
            cnt <= eff_int - DIV_W'(1);
            acc <= '0;
        end else if (tick) begin
            cnt <= reload;
            acc <= acc_full[FRAC_W-1:0];
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Phase counters. Power-of-two OVERSAMPLE makes the natural wrap of
    // the PH_W-bit adders the required modulo. rx_resync only touches the
    // rx phase, so tx bit timing is never disturbed by receive alignment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ph <= '0;
            tx_ph <= '0;
        end else if (!bus.enable) begin
            rx_ph <= '0;
            tx_ph <= '0;
        end else begin
            if (tick) begin
                tx_ph <= tx_ph + PH_W'(1);
            end

            if (bus.rx_resync) begin
                rx_ph <= '0;
            end else if (tick) begin
                rx_ph <= rx_ph + PH_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered strobes; decoded from pre-increment phase values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_tick_q   <= 1'b0;
            rx_sample_q <= 1'b0;
            tx_tick_q   <= 1'b0;
        end else begin
            rx_tick_q   <= tick;
            rx_sample_q <= tick && (rx_ph == PH_MID);
            tx_tick_q   <= tick && (tx_ph == PH_LAST);
        end
    end

    assign bus.rx_tick     = rx_tick_q;
    assign bus.rx_sample   = rx_sample_q;
    assign bus.tx_tick     = tx_tick_q;
    assign bus.rx_phase    = rx_ph;
    assign bus.div_pending = pending;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_baud_gen
// Description : Self-checking bench for uart_baud_gen. A negedge monitor
//               records every rx_tick (interval since previous tick or since
//               enable/reset release, strobes, phase); directed steps push
//               the expected ticks into a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_gen;

    localparam int DIV_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int OVERSAMPLE = 16;
    localparam int PH_W       = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .PH_W(PH_W)) bif ();

    uart_baud_gen #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .OVERSAMPLE (OVERSAMPLE),
        .RESET_DIV  (325),
        .RESET_FRAC (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    typedef struct {
        int gap;
        int sample;
        int tx;
        int phase;
    } tick_t;

    tick_t exp_q[$];
    tick_t obs_q[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int since     = 0;
    bit mon_on    = 1'b0;
    int m_rx      = 0;
    int m_tx      = 0;

    // Tick monitor
    always @(negedge clk) begin : mon
        tick_t t;
        if (!reset_n || !bif.enable) begin
            since = 0;
        end else begin
            since = since + 1;
            if (bif.rx_tick) begin
                t.gap    = since;
                t.sample = int'(bif.rx_sample);
                t.tx     = int'(bif.tx_tick);
                t.phase  = int'(bif.rx_phase);
                obs_q.push_back(t);
                since = 0;
            end
        end
        if (mon_on) begin
            n_asserts++;
            assert (((bif.rx_sample || bif.tx_tick) && !bif.rx_tick) === 1'b0) else begin
                n_fail++;
                $error("FAIL strobe_without_tick: observed sample=%0b tx=%0b tick=%0b required strobes only with tick",
                       bif.rx_sample, bif.tx_tick, bif.rx_tick);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected tick from the phase model; rs marks a coincident rx_resync.
    task automatic push_exp(input int gap, input bit rs = 1'b0);
        tick_t e;
        e.gap    = gap;
        e.sample = (m_rx == OVERSAMPLE / 2 - 1) ? 1 : 0;
        e.tx     = (m_tx == OVERSAMPLE - 1) ? 1 : 0;
        m_tx     = (m_tx + 1) % OVERSAMPLE;
        m_rx     = rs ? 0 : (m_rx + 1) % OVERSAMPLE;
        e.phase  = m_rx;
        exp_q.push_back(e);
    endtask

    task automatic check_n(input int n, input string tag, output int gap_sum);
        gap_sum = 0;
        for (int i = 0; i < n; i++) begin
            int    budget;
            tick_t o;
            tick_t e;
            budget = 2000;
            while (obs_q.size() == 0 && budget > 0) begin
                @(negedge clk);
                #1;
                budget--;
            end
            chk($sformatf("%s[%0d] tick_seen", tag, i), int'(obs_q.size() != 0), 1);
            if (obs_q.size() == 0) begin
                exp_q.delete();
                return;
            end
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d] gap", tag, i), o.gap, e.gap);
            chk($sformatf("%s[%0d] rx_sample", tag, i), o.sample, e.sample);
            chk($sformatf("%s[%0d] tx_tick", tag, i), o.tx, e.tx);
            chk($sformatf("%s[%0d] rx_phase", tag, i), o.phase, e.phase);
            gap_sum += o.gap;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bif.enable    = 1'b1;
        bif.div_int   = '0;
        bif.div_frac  = '0;
        bif.div_load  = 1'b0;
        bif.rx_resync = 1'b0;
        reset_n       = 1'b0;
        step(3);

        // Outputs during reset
        chk("reset rx_tick",     int'(bif.rx_tick),     0);
        chk("reset rx_sample",   int'(bif.rx_sample),   0);
        chk("reset tx_tick",     int'(bif.tx_tick),     0);
        chk("reset rx_phase",    int'(bif.rx_phase),    0);
        chk("reset div_pending", int'(bif.div_pending), 0);
        mon_on = 1'b1;

        // Default divisor 325/0
        reset_n = 1'b1;
        repeat (17) push_exp(325);
        check_n(17, "default", s);

        // Fractional 325 + 8/16
        bif.div_int  = 16'd325;
        bif.div_frac = 4'd8;
        bif.div_load = 1'b1;
        step(1);
        bif.div_load = 1'b0;
        chk("frac pending_set", int'(bif.div_pending), 1);
        push_exp(325);
        check_n(1, "frac_apply", s);
        chk("frac pending_clear", int'(bif.div_pending), 0);
        for (int i = 0; i < 16; i++) push_exp((i % 2 == 0) ? 325 : 326);
        check_n(16, "frac_run", s);
        chk("frac 16 periods", s, 5208);

        // Mid-period load 10/0, second load (20/0) in the applying cycle
        step(100);
        bif.div_int  = 16'd10;
        bif.div_frac = 4'd0;
        bif.div_load = 1'b1;
        step(1);
        bif.div_load = 1'b0;
        chk("mid pending_set", int'(bif.div_pending), 1);
        step(223);
        bif.div_int  = 16'd20;
        bif.div_load = 1'b1;
        step(1);
        bif.div_load = 1'b0;
        chk("second load pending_kept", int'(bif.div_pending), 1);
        push_exp(325);
        check_n(1, "mid_apply", s);
        push_exp(10);
        check_n(1, "div10", s);
        chk("div20 pending_clear", int'(bif.div_pending), 0);
        push_exp(20);
        push_exp(20);
        check_n(2, "div20", s);

        // rx_resync at rx_phase 5
        while (m_rx != 5) begin
            push_exp(20);
            check_n(1, "align", s);
        end
        chk("phase before resync", int'(bif.rx_phase), 5);
        step(5);
        bif.rx_resync = 1'b1;
        step(1);
        bif.rx_resync = 1'b0;
        chk("phase after resync", int'(bif.rx_phase), 0);
        m_rx = 0;
        repeat (16) push_exp(20);
        check_n(16, "post_resync", s);

        // rx_resync coincident with rx_tick
        step(19);
        bif.rx_resync = 1'b1;
        step(1);
        bif.rx_resync = 1'b0;
        push_exp(20, 1'b1);
        check_n(1, "resync_on_tick", s);
        repeat (16) push_exp(20);
        check_n(16, "post_resync2", s);

        // div_int = 0 behaves as 1
        bif.div_int  = 16'd0;
        bif.div_frac = 4'd0;
        bif.div_load = 1'b1;
        step(1);
        bif.div_load = 1'b0;
        push_exp(20);
        repeat (32) push_exp(1);
        check_n(33, "div0", s);

        // div_int = 1
        bif.div_int  = 16'd1;
        bif.div_load = 1'b1;
        step(1);
        bif.div_load = 1'b0;
        repeat (16) push_exp(1);
        check_n(16, "div1", s);
        chk("div1 continuous rx_tick", int'(bif.rx_tick), 1);

        // Mid-operation asynchronous reset
        reset_n = 1'b0;
        #1;
        chk("async reset rx_tick",     int'(bif.rx_tick),     0);
        chk("async reset tx_tick",     int'(bif.tx_tick),     0);
        chk("async reset rx_sample",   int'(bif.rx_sample),   0);
        chk("async reset rx_phase",    int'(bif.rx_phase),    0);
        chk("async reset div_pending", int'(bif.div_pending), 0);
        step(3);
        obs_q.delete();
        exp_q.delete();
        m_rx = 0;
        m_tx = 0;
        bif.enable = 1'b0;
        reset_n    = 1'b1;
        step(1);

        // Load while idle applies on the next clk
        bif.div_int  = 16'd30;
        bif.div_load = 1'b1;
        step(1);
        bif.div_load = 1'b0;
        chk("idle pending_set", int'(bif.div_pending), 1);
        step(1);
        chk("idle pending_clear", int'(bif.div_pending), 0);
        bif.enable = 1'b1;
        repeat (3) push_exp(30);
        check_n(3, "div30", s);

        // Enable toggle mid-period
        step(12);
        bif.enable = 1'b0;
        step(1);
        chk("disable rx_phase", int'(bif.rx_phase), 0);
        chk("disable rx_tick",  int'(bif.rx_tick),  0);
        m_rx = 0;
        m_tx = 0;
        step(4);
        bif.enable = 1'b1;
        repeat (3) push_exp(30);
        check_n(3, "reenable", s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised fractional baud-tick generator for the UART module; it replaces the fixed 10-bit integer divider. From the system clock it produces a single-cycle oversample tick for the receiver, a bit-rate tick for the transmitter and a mid-bit sample strobe. The divisor is runtime-loadable with glitch-free switchover. The receive bit phase can be re-aligned to a detected start-bit edge without disturbing transmit timing.

## Interface
Parameters:
- DIV_W, 16, width of integer divisor (oversample period in clk cycles)
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle)
- OVERSAMPLE, 16, rx ticks per bit; power of two, ≥4
- RESET_DIV, 325, integer divisor after reset
- RESET_FRAC, 0, fractional divisor after reset

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run tick generation; low holds the block idle
- div_int  in  DIV_W  integer divisor request
- div_frac  in  FRAC_W  fractional divisor request
- div_load  in  1  one-cycle pulse; capture div_int/div_frac
- rx_resync  in  1  one-cycle pulse; restart rx bit phase
- rx_tick  out  1  oversample tick, 1 clk wide
- rx_sample  out  1  mid-bit strobe, 1 clk wide
- rx_phase  out  log2(OVERSAMPLE)  rx phase within bit
- tx_tick  out  1  bit-rate tick, 1 clk wide
- div_pending  out  1  loaded divisor not yet applied

## Operation
- Registers: pending divisor (pend_int, pend_frac), active divisor (act_int, act_frac), down-counter cnt (DIV_W), fractional accumulator acc (FRAC_W), rx_ph and tx_ph (log2(OVERSAMPLE) each).
- Effective integer divisor = max(act_int, 1); div_int = 0 behaves as 1.
- Divider: cnt decrements on each enabled clk. When cnt == 0: rx_tick fires, acc ← (acc + act_frac) mod 2^FRAC_W, carry = overflow bit of that add, cnt ← eff_int − 1 + carry. Average period = act_int + act_frac/2^FRAC_W cycles.
- div_load: captures both inputs into pend_* and sets div_pending. When enable = 1, pend_* is copied to act_* at the next rx_tick, and that tick's reload uses the new value. When enable = 0, the copy happens on the next clk. div_pending clears in the same cycle the copy happens. A div_load arriving in the same cycle as the copy wins: pend_* takes the new value and div_pending stays set.
- rx_ph increments mod OVERSAMPLE on each rx_tick. rx_sample = rx_tick when rx_ph == OVERSAMPLE/2 − 1 (pre-increment value).
- tx_ph increments mod OVERSAMPLE on each rx_tick. tx_tick = rx_tick when tx_ph == OVERSAMPLE − 1.
- rx_resync: rx_ph ← 0 on the next edge. If the same cycle also carries rx_tick, resync wins and no increment happens. Divider, acc and tx_ph are unaffected.
- enable = 0: cnt ← eff_int − 1, acc ← 0, rx_ph ← 0, tx_ph ← 0, no ticks. pend/act registers keep their values.

## Timing
- Reset values: act_int = pend_int = RESET_DIV, act_frac = pend_frac = RESET_FRAC. cnt = RESET_DIV − 1, acc = 0, all phases 0. All outputs 0.
- All outputs are registered, driven straight from flops.
- The first rx_tick after reset release or enable rise occurs eff_int clk cycles after the first enabled edge. Subsequent ticks follow every eff_int + carry cycles.
- The new divisor takes effect on the period starting at the applying tick. There is no short or runt period.
- tx_tick and rx_sample always coincide with an rx_tick. tx_tick period = OVERSAMPLE rx periods.
- Mid-operation reset: asynchronous return to reset values, with outputs low in the same cycle.
- eff_int = 1 with act_frac = 0: rx_tick is continuously high. This is legal; each cycle counts as one tick.

## Test plan
- Reset, then enable = 1 with defaults (325/0): rx_tick every 325 cycles, tx_tick every 5200 cycles, rx_sample at rx_phase 7→8, all outputs 0 during reset.
- div_int = 325, div_frac = 8, load: rx_tick intervals alternate 325/326, 16 rx periods = 5208 cycles; div_pending high until the applying tick.
- Load 10/0 mid-period while running at 325: the current 325 period completes, then intervals of 10 follow; a second load in the applying cycle is retained and div_pending stays 1.
- rx_resync pulsed at rx_phase 5, including a pulse coincident with rx_tick: rx_phase goes to 0, the next rx_sample comes 8 rx ticks later, and tx_tick spacing stays unchanged.
- div_int = 0 and div_int = 1: rx_tick every cycle; tx_tick every 16 cycles.
- reset_n low for 3 cycles, then enable toggled low/high mid-period: outputs drop immediately, and the first tick comes eff_int cycles after re-enable.
